i2c_bus_arbiter: RTL and testbench

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

---
 rtl/i2c_bus_arbiter.sv | 176 +++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that gives four requesters exclusive use of a single shared I2C engine.
// Optional macro I2C_ARB_TIMEOUT_EN adds a wait limit that resets the engine and reports an error.
module i2c_bus_arbiter #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [3:0]  req,
    input  logic [27:0] req_slave_addr,
    input  logic [63:0] req_reg_addr,
    input  logic [3:0]  req_is_read,
    input  logic [39:0] req_nb_bytes,

    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic [3:0]  err,
    output logic [15:0] rdata,

    output logic        i2c_start,
    output logic [6:0]  i2c_slave_addr,
    output logic [15:0] i2c_reg_addr,
    output logic        i2c_is_read,
    output logic [9:0]  i2c_nb_bytes,
    input  logic        i2c_ready,
    input  logic        i2c_error,
    input  logic [15:0] i2c_data_out,
    output logic        i2c_reset
);

    localparam int unsigned StableW = $clog2(STABLE_CYCLES + 1);

    if (STABLE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("STABLE_CYCLES and TIMEOUT_CYCLES must both be non-zero");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone,
        StRelease
    } state_e;

    state_e               state;
    logic [1:0]           owner;
    logic [1:0]           last_grant;
    logic [StableW-1:0]   stable_cnt;
    logic                 err_latch;

    // Round-robin pick: scan offsets 4..1 so the smallest offset after last_grant wins.
    logic [1:0] sel_idx;
    logic [1:0] cand;
    logic       sel_valid;

    always_comb begin
        sel_idx   = 2'd0;
        cand      = 2'd0;
        sel_valid = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            cand = last_grant + 2'(i);
            if (req[cand]) begin
                sel_idx   = cand;
                sel_valid = 1'b1;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TmoW-1:0] tmo_cnt;
    logic            tmo_reset;

    assign i2c_reset = reset | tmo_reset;
`else
    assign i2c_reset = reset;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= StIdle;
            grant          <= '0;
            done           <= '0;
            err            <= '0;
            rdata          <= '0;
            i2c_start      <= 1'b0;
            i2c_slave_addr <= '0;
            i2c_reg_addr   <= '0;
            i2c_is_read    <= 1'b0;
            i2c_nb_bytes   <= '0;
            owner          <= 2'd0;
            last_grant     <= 2'd3;
            stable_cnt     <= '0;
            err_latch      <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt        <= '0;
            tmo_reset      <= 1'b0;
`endif
        end else begin
            done      <= '0;
            err       <= '0;
            i2c_start <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_reset <= 1'b0;
`endif
            case (state)
                StIdle: begin
                    if (sel_valid) begin
                        state          <= StLaunch;
                        grant          <= 4'b0001 << sel_idx;
                        owner          <= sel_idx;
                        i2c_start      <= 1'b1;
                        i2c_slave_addr <= req_slave_addr[sel_idx*7 +: 7];
                        i2c_reg_addr   <= req_reg_addr[sel_idx*16 +: 16];
                        i2c_is_read    <= req_is_read[sel_idx];
                        i2c_nb_bytes   <= req_nb_bytes[sel_idx*10 +: 10];
                        err_latch      <= 1'b0;
                    end
                end
                StLaunch: begin
                    state      <= StWaitBusy;
                    stable_cnt <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
                    tmo_cnt    <= '0;
`endif
                end
                StWaitBusy: begin
                    if (!i2c_ready) begin
                        state      <= StWaitDone;
                        stable_cnt <= '0;
                    end
                end
                StWaitDone: begin
                    err_latch <= err_latch | i2c_error;
                    if (i2c_ready) begin
                        if (stable_cnt == StableW'(STABLE_CYCLES - 1)) begin
                            state <= StRelease;
                            done  <= grant;
                            err   <= (err_latch | i2c_error) ? grant : 4'b0000;
                            rdata <= i2c_data_out;
                        end else begin
                            stable_cnt <= stable_cnt + 1'b1;
                        end
                    end else begin
                        stable_cnt <= '0;
                    end
                end
                StRelease: begin
                    state      <= StIdle;
                    grant      <= '0;
                    last_grant <= owner;
                end
                default: state <= StIdle;
            endcase

`ifdef I2C_ARB_TIMEOUT_EN
            // The limit overrides a completion landing on the same cycle.
            if (state == StWaitBusy || state == StWaitDone) begin
                if (tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    state     <= StRelease;
                    done      <= grant;
                    err       <= grant;
                    err_latch <= 1'b1;
                    rdata     <= '0;
                    tmo_reset <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Randomized bench for i2c_bus_arbiter: drives an engine model and checks against a
// transaction-level model of round-robin ownership, completion timing and result fields.
module tb_i2c_bus_arbiter;

    localparam int unsigned Stable  = 4;
    localparam int unsigned Timeout = 100;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [27:0] req_slave_addr;
    logic [63:0] req_reg_addr;
    logic [3:0]  req_is_read;
    logic [39:0] req_nb_bytes;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  err;
    logic [15:0] rdata;
    logic        i2c_start;
    logic [6:0]  i2c_slave_addr;
    logic [15:0] i2c_reg_addr;
    logic        i2c_is_read;
    logic [9:0]  i2c_nb_bytes;
    logic        i2c_ready;
    logic        i2c_error;
    logic [15:0] i2c_data_out;
    logic        i2c_reset;

    always #5 clock = ~clock;

    i2c_bus_arbiter #(
        .STABLE_CYCLES  (Stable),
        .TIMEOUT_CYCLES (Timeout)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .req_slave_addr (req_slave_addr),
        .req_reg_addr   (req_reg_addr),
        .req_is_read    (req_is_read),
        .req_nb_bytes   (req_nb_bytes),
        .grant          (grant),
        .done           (done),
        .err            (err),
        .rdata          (rdata),
        .i2c_start      (i2c_start),
        .i2c_slave_addr (i2c_slave_addr),
        .i2c_reg_addr   (i2c_reg_addr),
        .i2c_is_read    (i2c_is_read),
        .i2c_nb_bytes   (i2c_nb_bytes),
        .i2c_ready      (i2c_ready),
        .i2c_error      (i2c_error),
        .i2c_data_out   (i2c_data_out),
        .i2c_reset      (i2c_reset)
    );

    int checks   = 0;
    int failures = 0;
    int last_owner = 3;

    logic [6:0]  f_sa [4];
    logic [15:0] f_ra [4];
    logic        f_rd [4];
    logic [9:0]  f_nb [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int off = 1; off <= 4; off++) begin
            if (r[(last + off) % 4]) return (last + off) % 4;
        end
        return -1;
    endfunction

    task automatic drive_fields();
        for (int k = 0; k < 4; k++) begin
            req_slave_addr[k*7 +: 7]  = f_sa[k];
            req_reg_addr[k*16 +: 16]  = f_ra[k];
            req_is_read[k]            = f_rd[k];
            req_nb_bytes[k*10 +: 10]  = f_nb[k];
        end
    endtask

    task automatic randomize_fields();
        for (int k = 0; k < 4; k++) begin
            f_sa[k] = 7'($urandom);
            f_ra[k] = 16'($urandom);
            f_rd[k] = 1'($urandom);
            f_nb[k] = 10'($urandom);
        end
        drive_fields();
    endtask

    // Entered and left on a falling edge with the arbiter idle.
    task automatic run_txn(input logic [3:0] pattern, input int busy_ones, input int low_len,
                           input bit glitch, input int err_at, input logic [15:0] final_data,
                           input bit hold_req);
        int          owner;
        int          last_idx;
        logic [6:0]  e_sa;
        logic [15:0] e_ra;
        logic        e_rd;
        logic [9:0]  e_nb;
        bit          seq[$];

        owner = rr_pick(pattern, last_owner);
        req = pattern;
        @(negedge clock);
        check_eq("grant", grant, 32'(4'b0001 << owner));
        check_eq("start_pulse", i2c_start, 1);
        e_sa = f_sa[owner];
        e_ra = f_ra[owner];
        e_rd = f_rd[owner];
        e_nb = f_nb[owner];
        check_eq("slave_addr", i2c_slave_addr, e_sa);
        check_eq("reg_addr", i2c_reg_addr, e_ra);
        check_eq("is_read", i2c_is_read, e_rd);
        check_eq("nb_bytes", i2c_nb_bytes, e_nb);
        i2c_ready = 1'b1;

        seq = {};
        repeat (busy_ones) seq.push_back(1'b1);
        repeat (low_len) seq.push_back(1'b0);
        if (glitch) begin
            seq.push_back(1'b1); seq.push_back(1'b1); seq.push_back(1'b1); seq.push_back(1'b0);
        end
        repeat (Stable) seq.push_back(1'b1);
        last_idx = seq.size() - 1;

        for (int k = 0; k <= last_idx; k++) begin
            @(negedge clock);
            if (k == 0) check_eq("start_once", i2c_start, 0);
            check_eq("no_early_done", done, 0);
            check_eq("grant_held", grant, 32'(4'b0001 << owner));
            if (k == 1) randomize_fields();
            if (!hold_req) req = 4'($urandom);
            i2c_ready    = seq[k];
            i2c_error    = (k == err_at);
            i2c_data_out = (k == last_idx) ? final_data : 16'($urandom);
        end

        @(negedge clock);
        i2c_ready = 1'b1;
        i2c_error = 1'b0;
        check_eq("done", done, 32'(4'b0001 << owner));
        check_eq("err", err, (err_at >= 0) ? 32'(4'b0001 << owner) : 0);
        check_eq("rdata", rdata, final_data);
        check_eq("fields_held", {i2c_slave_addr, i2c_reg_addr, i2c_is_read, i2c_nb_bytes},
                 {e_sa, e_ra, e_rd, e_nb});
        check_eq("no_engine_reset", i2c_reset, 0);
        last_owner = owner;

        @(negedge clock);
        check_eq("done_one_cycle", done, 0);
        check_eq("grant_free", grant, 0);
        check_eq("rdata_hold", rdata, final_data);
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic timeout_test();
        int owner;
        int waited;
        randomize_fields();
        req = 4'($urandom_range(15, 1));
        owner = rr_pick(req, last_owner);
        @(negedge clock);
        check_eq("tmo_grant", grant, 32'(4'b0001 << owner));
        i2c_ready = 1'b0;
        waited = 0;
        while (done == 4'b0000 && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        check_eq("tmo_window", (waited >= 99 && waited <= 103), 1);
        check_eq("tmo_done", done, 32'(4'b0001 << owner));
        check_eq("tmo_err", err, 32'(4'b0001 << owner));
        check_eq("tmo_rdata", rdata, 0);
        check_eq("tmo_engine_reset", i2c_reset, 1);
        i2c_ready = 1'b1;
        last_owner = owner;
        @(negedge clock);
        check_eq("tmo_reset_pulse", i2c_reset, 0);
        check_eq("tmo_grant_free", grant, 0);
    endtask
`endif

    initial begin
        reset          = 1'b1;
        req            = '0;
        req_slave_addr = '0;
        req_reg_addr   = '0;
        req_is_read    = '0;
        req_nb_bytes   = '0;
        i2c_ready      = 1'b1;
        i2c_error      = 1'b0;
        i2c_data_out   = '0;

        repeat (3) @(negedge clock);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_done_err", {done, err}, 0);
        check_eq("rst_start", i2c_start, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_fields", {i2c_slave_addr, i2c_reg_addr, i2c_is_read, i2c_nb_bytes}, 0);
        check_eq("rst_engine_reset", i2c_reset, 1);
        reset = 1'b0;
        @(negedge clock);
        check_eq("post_rst_engine_reset", i2c_reset, 0);

        // Contention from reset: requester 0 first, then rotating.
        for (int t = 0; t < 4; t++) begin
            randomize_fields();
            run_txn(4'b1111, $urandom_range(2, 0), $urandom_range(10, 1), 1'b0, -1,
                    16'($urandom), 1'b1);
        end

        // Single read of 0x29/0x010F with a 50-cycle busy engine.
        randomize_fields();
        f_sa[0] = 7'h29;
        f_ra[0] = 16'h010F;
        f_rd[0] = 1'b1;
        drive_fields();
        run_txn(4'b0001, 0, 50, 1'b0, -1, 16'hEACC, 1'b0);

        randomize_fields();
        run_txn(4'b0100, 1, 5, 1'b0, 3, 16'($urandom), 1'b0);
        randomize_fields();
        run_txn(4'b0010, 0, 3, 1'b1, -1, 16'($urandom), 1'b0);

        for (int t = 0; t < 30; t++) begin
            logic [3:0] pat;
            int         b;
            int         lo;
            int         ea;
            pat = 4'($urandom);
            if (pat == 4'b0000) begin
                req = '0;
                repeat (3) begin
                    @(negedge clock);
                    check_eq("idle_grant", grant, 0);
                end
            end else begin
                b  = $urandom_range(3, 0);
                lo = $urandom_range(40, 1);
                ea = -1;
                if (lo >= 2 && $urandom_range(3, 0) == 0) ea = b + 1 + $urandom_range(lo - 2, 0);
                randomize_fields();
                run_txn(pat, b, lo, 1'($urandom), ea, 16'($urandom), 1'b0);
            end
        end

`ifdef I2C_ARB_TIMEOUT_EN
        timeout_test();
        randomize_fields();
        run_txn(4'($urandom_range(15, 1)), 0, 4, 1'b0, -1, 16'($urandom), 1'b0);
`endif

        // Reset while waiting for completion aborts without a done pulse.
        begin
            int owner;
            randomize_fields();
            req = 4'b1111;
            owner = rr_pick(req, last_owner);
            @(negedge clock);
            check_eq("abort_grant", grant, 32'(4'b0001 << owner));
            @(negedge clock);
            i2c_ready = 1'b0;
            repeat (4) @(negedge clock);
            reset = 1'b1;
            #1;
            check_eq("abort_engine_reset", i2c_reset, 1);
            @(negedge clock);
            check_eq("abort_grant_clear", grant, 0);
            check_eq("abort_no_done", {done, err}, 0);
            check_eq("abort_outputs", {i2c_start, rdata, i2c_slave_addr}, 0);
            @(negedge clock);
            reset     = 1'b0;
            req       = '0;
            i2c_ready = 1'b1;
            last_owner = 3;
            repeat (4) begin
                @(negedge clock);
                check_eq("abort_quiet", {grant, done}, 0);
            end
            randomize_fields();
            run_txn(4'b1111, 0, 2, 1'b0, -1, 16'($urandom), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
